// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state encoding and
// the requester identifier stored in the pending-read FIFO.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   typedef logic req_id_t;

   localparam req_id_t REQ_M0 = 1'b0;
   localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/id_fifo.sv
// Small FIFO of requester IDs, one entry per read that the shared memory has
// accepted but not yet answered. A pop on a full FIFO frees room for a push in
// the same cycle.
module id_fifo
   import mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  req_id_t                  din_i,
   output req_id_t                  dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   req_id_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push_s;
   logic            do_pop_s;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign count_o   = count_q;
   assign dout_o    = mem_q[rd_ptr_q];
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);

   // Storage, power-of-two pointers that wrap naturally, and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= REQ_M0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one shared memory. Commands are
// granted round-robin; read responses are steered back by a FIFO of IDs.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_read,
   input  logic              m0_write,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_read,
   input  logic              m1_write,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic [DATA_W-1:0] s_writedata,
   output logic              s_read,
   output logic              s_write,
   input  logic              s_waitrequest,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid,
   output logic              err
);

   localparam int CW = $clog2(MAX_PENDING) + 1;

   arb_state_e    state_q, state_d;
   req_id_t       last_q, last_d;
   logic          err_q;

   logic          req0_s, req1_s, own_req_s, oth_req_s;
   logic          granted_s, sel_read_s, sel_write_s;
   req_id_t       gnt_id_s, head_id_s;
   arb_state_e    oth_state_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [CW-1:0] pend_cnt_s;
   logic          rsp_pop_s, block_rd_s, accept_s, push_s;

   assign req0_s      = m0_read | m0_write;
   assign req1_s      = m1_read | m1_write;
   assign granted_s   = (state_q == GRANT0) || (state_q == GRANT1);
   assign gnt_id_s    = (state_q == GRANT1) ? REQ_M1 : REQ_M0;
   assign own_req_s   = (gnt_id_s == REQ_M1) ? req1_s : req0_s;
   assign oth_req_s   = (gnt_id_s == REQ_M1) ? req0_s : req1_s;
   assign oth_state_s = (gnt_id_s == REQ_M1) ? GRANT0 : GRANT1;
   assign sel_read_s  = (gnt_id_s == REQ_M1) ? m1_read  : m0_read;
   assign sel_write_s = (gnt_id_s == REQ_M1) ? m1_write : m0_write;

   // A response arriving this cycle frees a slot, so a full FIFO need not stall.
   assign rsp_pop_s   = s_readdatavalid & ~fifo_empty_s;
   assign block_rd_s  = sel_read_s & fifo_full_s & ~rsp_pop_s;

   assign s_read      = granted_s & sel_read_s & ~block_rd_s;
   assign s_write     = granted_s & sel_write_s;
   assign s_address   = (gnt_id_s == REQ_M1) ? m1_address   : m0_address;
   assign s_writedata = (gnt_id_s == REQ_M1) ? m1_writedata : m0_writedata;
   assign accept_s    = (s_read | s_write) & ~s_waitrequest;
   assign push_s      = s_read & ~s_waitrequest;

   assign m0_waitrequest   = (state_q == GRANT0) ? (s_waitrequest | block_rd_s) : 1'b1;
   assign m1_waitrequest   = (state_q == GRANT1) ? (s_waitrequest | block_rd_s) : 1'b1;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = rsp_pop_s & (head_id_s == REQ_M0);
   assign m1_readdatavalid = rsp_pop_s & (head_id_s == REQ_M1);
   assign err              = err_q;

   id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s),
      .pop_i   (rsp_pop_s),
      .din_i   (gnt_id_s),
      .dout_o  (head_id_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (pend_cnt_s)
   );

   // Grant selection; a granted requester that withdraws its request releases the grant.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req0_s && req1_s) begin
               state_d = (last_q == REQ_M1) ? GRANT0 : GRANT1;
            end else if (req0_s) begin
               state_d = GRANT0;
            end else if (req1_s) begin
               state_d = GRANT1;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT0, GRANT1: begin
            if (accept_s) begin
               last_d = gnt_id_s;
               if (oth_req_s) begin
                  state_d = oth_state_s;
               end else if (own_req_s) begin
                  state_d = state_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (!own_req_s) begin
               state_d = oth_req_s ? oth_state_s : IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            last_d  = last_q;
         end
      endcase
   end

   // FSM, round-robin history and sticky error for orphan responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= REQ_M1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         if (s_readdatavalid && (pend_cnt_s == '0)) begin
            err_q <= 1'b1;
         end else begin
            err_q <= err_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single-grant cases plus
// hand-written multi-cycle sequences against a small in-order memory model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [31:0] s_address, s_writedata;
   logic        s_read, s_write;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic        err;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PENDING(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(m0_address), .m0_writedata(m0_writedata),
      .m0_read(m0_read), .m0_write(m0_write),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_read(m1_read), .m1_write(m1_write),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_writedata(s_writedata),
      .s_read(s_read), .s_write(s_write),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        m0_rd, m0_wr, m1_rd, m1_wr, swait;
      logic        exp_rd, exp_wr;
      logic [31:0] exp_addr;
      logic        exp_w0, exp_w1;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   logic [31:0] mem [16];
   rsp_t        rq [$];
   int          cyc, lat;
   bit          hold_rsp, force_rdv;
   int          passed, total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory model: accepted commands are seen at the falling edge, responses
   // are presented just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (s_write && !s_waitrequest) mem[s_address[3:0]] = s_writedata;
      if (s_read && !s_waitrequest) rq.push_back('{mem[s_address[3:0]], cyc + lat});
      @(posedge clk);
      #1;
      cyc++;
      if (force_rdv) begin
         s_readdatavalid = 1'b1;
         s_readdata      = 32'h5A5A_5A5A;
      end else if (!hold_rsp && rq.size() > 0 && rq[0].due <= cyc) begin
         s_readdatavalid = 1'b1;
         s_readdata      = rq[0].data;
         void'(rq.pop_front());
      end else begin
         s_readdatavalid = 1'b0;
         s_readdata      = 32'h0;
      end
   endtask

   task automatic clear_inputs();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      m0_address = 32'h10; m1_address = 32'h20;
      m0_writedata = 32'h0; m1_writedata = 32'h0;
      s_waitrequest = 1'b0; hold_rsp = 1'b0; force_rdv = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      rq.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   vec_t vecs[6];
   bit   found;

   initial begin
      passed = 0; total = 0; cyc = 0; lat = 3;
      s_readdatavalid = 1'b0; s_readdata = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
      clear_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_s_read", s_read, 32'd0);
      chk("rst_s_write", s_write, 32'd0);
      chk("rst_m0_wait", m0_waitrequest, 32'd1);
      chk("rst_m1_wait", m1_waitrequest, 32'd1);
      chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 32'd0);
      chk("rst_err", err, 32'd0);

      //          m0r   m0w   m1r   m1w   swait exrd  exwr  addr   w0    w1
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};

      for (int v = 0; v < 6; v++) begin
         do_reset();
         m0_read = vecs[v].m0_rd; m0_write = vecs[v].m0_wr;
         m1_read = vecs[v].m1_rd; m1_write = vecs[v].m1_wr;
         s_waitrequest = vecs[v].swait;
         #1;
         chk($sformatf("v%0d_idle_cmd", v), {s_read, s_write}, 32'd0);
         tick();
         #1;
         chk($sformatf("v%0d_s_read", v), s_read, vecs[v].exp_rd);
         chk($sformatf("v%0d_s_write", v), s_write, vecs[v].exp_wr);
         chk($sformatf("v%0d_m0_wait", v), m0_waitrequest, vecs[v].exp_w0);
         chk($sformatf("v%0d_m1_wait", v), m1_waitrequest, vecs[v].exp_w1);
         if (vecs[v].exp_rd || vecs[v].exp_wr)
            chk($sformatf("v%0d_s_addr", v), s_address, vecs[v].exp_addr);
      end

      // Single write from m0 reaches memory with one cycle of arbitration.
      do_reset();
      m0_write = 1'b1; m0_address = 32'd5; m0_writedata = 32'hDEAD_BEEF;
      #1;
      chk("wr_idle_wait", m0_waitrequest, 32'd1);
      tick();
      #1;
      chk("wr_s_write", s_write, 32'd1);
      chk("wr_m0_wait", m0_waitrequest, 32'd0);
      chk("wr_s_wdata", s_writedata, 32'hDEAD_BEEF);
      tick();
      m0_write = 1'b0;
      chk("wr_mem5", mem[5], 32'hDEAD_BEEF);

      // Simultaneous reads: m0 then m1 back to back, responses in order.
      do_reset();
      m0_read = 1'b1; m0_address = 32'd8;
      m1_read = 1'b1; m1_address = 32'd9;
      tick();
      #1;
      chk("tie_g0_read", s_read, 32'd1);
      chk("tie_g0_addr", s_address, 32'd8);
      chk("tie_g0_wait", {m1_waitrequest, m0_waitrequest}, 32'b10);
      tick();
      m0_read = 1'b0;
      #1;
      chk("tie_g1_read", s_read, 32'd1);
      chk("tie_g1_addr", s_address, 32'd9);
      chk("tie_g1_wait", {m1_waitrequest, m0_waitrequest}, 32'b01);
      tick();
      m1_read = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         #1;
         if (m0_readdatavalid || m1_readdatavalid) found = 1'b1;
      end
      chk("tie_rsp_seen", found, 32'd1);
      chk("tie_rsp0_valid", {m1_readdatavalid, m0_readdatavalid}, 32'b01);
      chk("tie_rsp0_data", m0_readdata, 32'hA000_0008);
      tick();
      #1;
      chk("tie_rsp1_valid", {m1_readdatavalid, m0_readdatavalid}, 32'b10);
      chk("tie_rsp1_data", m1_readdata, 32'hA000_0009);
      chk("tie_err", err, 32'd0);

      // m1 write stalled by the memory for four cycles while m0 waits.
      do_reset();
      m1_write = 1'b1; m1_address = 32'h33; m1_writedata = 32'hCAFE_0033;
      s_waitrequest = 1'b1;
      tick();
      m0_read = 1'b1; m0_address = 32'h4;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("stall%0d_cmd", i), {s_read, s_write}, 32'b01);
         chk($sformatf("stall%0d_addr", i), s_address, 32'h33);
         chk($sformatf("stall%0d_wait", i), {m1_waitrequest, m0_waitrequest}, 32'b11);
         tick();
      end
      s_waitrequest = 1'b0;
      #1;
      chk("stall_release", {m1_waitrequest, m0_waitrequest, s_write}, 32'b011);
      tick();
      m1_write = 1'b0;
      #1;
      chk("stall_next_g0", {s_read, m0_waitrequest}, 32'b10);
      chk("stall_next_addr", s_address, 32'h4);
      chk("stall_mem", mem[3], 32'hCAFE_0033);
      tick();
      m0_read = 1'b0;

      // Four outstanding reads fill the FIFO; the fifth waits for a response.
      do_reset();
      hold_rsp = 1'b1;
      m0_read = 1'b1; m0_address = 32'd0;
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("fill%0d_read", i), s_read, 32'd1);
         tick();
         m0_address = 32'(i + 1);
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("full%0d_blocked", i), {s_read, m0_waitrequest}, 32'b01);
         tick();
      end
      hold_rsp = 1'b0;
      tick();
      hold_rsp = 1'b1;
      #1;
      chk("full_pop_valid", m0_readdatavalid, 32'd1);
      chk("full_pop_data", m0_readdata, 32'hA000_0000);
      chk("full_pop_accept", {s_read, m0_waitrequest}, 32'b10);
      tick();
      m0_address = 32'd5;
      #1;
      chk("full_still4", {s_read, m0_waitrequest}, 32'b01);
      m0_read = 1'b0;
      hold_rsp = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("full_err", err, 32'd0);

      // Orphan response is flagged and the flag holds until reset.
      do_reset();
      force_rdv = 1'b1;
      tick();
      force_rdv = 1'b0;
      #1;
      chk("orphan_no_valid", {m1_readdatavalid, m0_readdatavalid}, 32'd0);
      tick();
      #1;
      chk("orphan_err", err, 32'd1);
      for (int i = 0; i < 3; i++) tick();
      #1;
      chk("orphan_err_sticky", err, 32'd1);
      do_reset();
      #1;
      chk("orphan_err_cleared", err, 32'd0);

      // Reset with two reads outstanding; their late responses become orphans.
      lat = 20;
      m0_read = 1'b1; m0_address = 32'd1;
      tick();
      tick();
      m0_address = 32'd2;
      tick();
      m0_address = 32'd3;
      #1;
      chk("mid_pre_read", s_read, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd", {s_read, s_write}, 32'd0);
      chk("mid_rst_wait", {m1_waitrequest, m0_waitrequest}, 32'b11);
      m0_read = 1'b0;
      tick();
      rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         #1;
         if (s_readdatavalid) found = 1'b1;
      end
      chk("mid_late_seen", found, 32'd1);
      chk("mid_late_no_valid", {m1_readdatavalid, m0_readdatavalid}, 32'd0);
      tick();
      #1;
      chk("mid_late_err", err, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
